// File: rtl/sym_restore_pkg.sv
// Shared definitions for the sign-fold restore path: mode encodings, sign FIFO
// entry layout, fixed-point ONE constant and signed saturation helper.
package sym_restore_pkg;

  localparam logic MODE_SIGMOID = 1'b0;
  localparam logic MODE_TANH    = 1'b1;

  typedef struct packed {
    logic mode;
    logic sign_pos;
  } sign_entry_t;

  // Entry substituted when a result returns with no flag available.
  localparam sign_entry_t ENTRY_PASS = '{mode: MODE_SIGMOID, sign_pos: 1'b1};

  function automatic int unsigned one_from_frac(input int unsigned frac);
    return 32'd1 << frac;
  endfunction

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                     input int unsigned dw);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (dw - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/sym_sign_fifo.sv
// First-word-fall-through FIFO of {mode, sign_pos} flags with occupancy count,
// empty bypass and single-cycle overflow/underflow pulses.
module sym_sign_fifo
  import sym_restore_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  sign_entry_t   wdata,
  output sign_entry_t   rdata,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          udf
);

  sign_entry_t   mem_q [DEPTH];
  sign_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty;
  logic          full;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    rdata   = ENTRY_PASS;
    ovf     = 1'b0;
    udf     = 1'b0;
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));

    if (pop) begin
      if (!empty) begin
        rdata = mem_q[rd_q];
        rd_d  = rd_q + AW'(1);
        if (!push) count_d = count_q - CW'(1);
      end else if (push) begin
        rdata = wdata;
      end else begin
        udf = 1'b1;
      end
    end

    // A push consumed by the empty bypass never touches storage.
    if (push && !(pop && empty)) begin
      if (pop || !full) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + AW'(1);
        if (!pop) count_d = count_q + CW'(1);
      end else begin
        ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= ENTRY_PASS;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sym_restore.sv
// Pairs buffered sign flags with magnitude-domain LUT results and restores
// sigmoid/tanh by symmetry. Define SYM_RESTORE_ERR_EN for sticky error flags.
module sym_restore
  import sym_restore_pkg::*;
#(
  parameter int DW    = 16,
  parameter int FRAC  = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     sign_valid,
  input  logic                     sign_pos,
  input  logic                     mode,
  input  logic                     mag_valid,
  input  logic [DW-1:0]            mag_y,
  output logic [DW-1:0]            y_out,
  output logic                     y_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_ovf,
  output logic                     err_udf,
  input  logic                     err_clr
);

  localparam logic signed [DW:0] ONE_S = (DW+1)'(one_from_frac(FRAC));

  logic             push;
  logic             pop;
  sign_entry_t      head;
  logic             ovf_pulse;
  logic             udf_pulse;
  logic signed [DW:0] mag_ext;
  logic signed [DW:0] diff;
  logic signed [DW:0] restored;
  logic [DW-1:0]    y_out_q, y_out_d;
  logic             y_valid_q, y_valid_d;

  assign push = en & sign_valid;
  assign pop  = en & mag_valid;

  sym_sign_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ('{mode: mode, sign_pos: sign_pos}),
    .rdata (head),
    .count (count),
    .ovf   (ovf_pulse),
    .udf   (udf_pulse)
  );

  always_comb begin
    mag_ext  = {1'b0, mag_y};
    diff     = ONE_S - mag_ext;
    restored = mag_ext;
    if (!head.sign_pos) begin
      if (head.mode == MODE_TANH) restored = -mag_ext;
      else                        restored = (diff < 0) ? '0 : diff;
    end
    y_valid_d = pop;
    y_out_d   = pop ? DW'(sat_signed(32'(restored), DW)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_out_q   <= y_out_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

`ifdef SYM_RESTORE_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_ovf_d = err_clr ? 1'b0 : err_ovf_q;
    err_udf_d = err_clr ? 1'b0 : err_udf_q;
    if (ovf_pulse) err_ovf_d = 1'b1;
    if (udf_pulse) err_udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, ovf_pulse, udf_pulse};
  assign err_ovf    = 1'b0;
  assign err_udf    = 1'b0;
`endif

endmodule

// File: doc/sym_restore.md
Name: sym_restore

Overview:
- Back end of the sign-fold path in the sigmoid/tanh units.
- Upstream, the sign comparator emits a per-sample "x > 0" flag. The LUT/interpolator then evaluates the function on |x| with several cycles of latency.
- This block buffers the sign flags (and function mode) in order, pairs each one with the returning magnitude-domain result, and restores the final value by symmetry:
  - sigmoid: y or ONE − y
  - tanh: y or −y

Parameters:
- DW, 16, data width of mag_y and y_out (two's complement out, non-negative in).
- FRAC, 12, fractional bits; ONE = 2^FRAC.
- DEPTH, 8, sign FIFO depth (power of two, ≥2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  block enable; 0 = no push/pop, outputs forced to 0 next cycle
- sign_valid  in  1  sign flag strobe from the comparator
- sign_pos  in  1  1 = x > 0, 0 = x ≤ 0
- mode  in  1  sampled with sign_valid; 0 = sigmoid, 1 = tanh
- mag_valid  in  1  LUT result strobe
- mag_y  in  DW  f(|x|), unsigned in [0, ONE]
- y_out  out  DW  restored result, signed
- y_valid  out  1  y_out valid strobe
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- err_ovf  out  1  sticky: push dropped because FIFO full
- err_udf  out  1  sticky: pop attempted while FIFO empty
- err_clr  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset (rst=1, asynchronous): pointers and count = 0, y_out = 0, y_valid = 0, err_ovf = 0, err_udf = 0. Reset asserted mid-operation discards all buffered flags.
- Push: en & sign_valid writes {mode, sign_pos} at the write pointer.
- Pop: en & mag_valid reads the entry at the read pointer.
- Pointers wrap modulo DEPTH. The FIFO is first-word-fall-through: the head entry is readable combinationally.
- Simultaneous push and pop:
  - Not empty: both happen; count unchanged.
  - Empty: bypass, i.e. the incoming {mode, sign_pos} is used directly and nothing is stored.
  - Full: both happen; no overflow.
- Full with push and no pop: entry dropped, count stays DEPTH, err_ovf ← 1.
- Empty with pop and no push: uses {mode=0, sign_pos=1} (pass-through), err_udf ← 1, y_valid still asserted.
- Latency: y_out/y_valid are registered exactly 1 cycle after the mag_valid edge. Output throughput is one result per cycle.
- Restoration arithmetic, done in DW+1 bits then saturated to the DW signed range:
  - sign_pos = 1: y_out = mag_y (both modes).
  - sigmoid, sign_pos = 0: y_out = ONE − mag_y; a negative result clamps to 0.
  - tanh, sign_pos = 0: y_out = −mag_y.
  - x = 0 is classified as non-positive: sigmoid gives ONE − 0.5 = 0.5 and tanh gives −0 = 0, both correct.
- en = 0: no push, no pop, count holds, and on the next cycle y_valid = 0 and y_out = 0. Error flags hold.
- err_clr: clears both flags next cycle. If an error event occurs in the same cycle, the set wins.
- y_valid is a single-cycle strobe per pop. There is no backpressure; the downstream block must accept every result.

Optional Feature:
- Macro SYM_RESTORE_ERR_EN.
- Defined: err_ovf/err_udf are sticky as described above, and err_clr is functional.
- Undefined: both flags are tied to 0 and err_clr is ignored. Drop and underflow behaviour of the datapath is unchanged.

Decomposition:
- Shared package:
  - MODE_SIGMOID = 0, MODE_TANH = 1
  - ONE-from-FRAC constant function
  - saturation helper function for DW+1 → DW signed
- One natural sub-module: sym_sign_fifo. It is a DEPTH×2-bit FWFT FIFO with count, full/empty, empty-bypass, and ovf/udf pulses.
- Restoration arithmetic and the output register stay in the top module.

Test Plan (DW=16, FRAC=12, ONE=4096, DEPTH=8):
- Sigmoid positive: sign_pos=1, mode=0; 3 cycles later mag_y=3000 → next cycle y_out=3000, y_valid=1 for exactly 1 cycle.
- Sigmoid non-positive: sign_pos=0, mode=0, mag_y=3000 → y_out=1096. With mag_y=4100 → y_out=0 (clamped).
- Tanh ordering: push (pos=1, 0, 1, 0), mode=1, back-to-back; then mag 100, 200, 300, 400 → y_out 100, −200 (0xFF38), 300, −400 in order; count returns to 0.
- Bypass: FIFO empty, sign_valid, mag_valid and sign_pos=0 in the same cycle, mode=1, mag_y=2000 → y_out=−2000 (0xF830), count stays 0, err_udf=0.
- Overflow/underflow:
  - 9 pushes with no pops → count=8, err_ovf=1, 9th entry lost; 8 pops return the first 8 in order.
  - A further pop → err_udf=1, y_out=mag_y.
  - err_clr → both flags 0.
- Reset mid-operation: push 3 entries, pulse rst asynchronously between edges → count=0, y_valid=0 immediately. A following pop sets err_udf.
